pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage; successor to the single 32-bit PC register with stall.
- Registered PC with configurable width, increment, reset and exception vectors.
- Prioritised next-PC selection: exception, stall-hold, return, jump, branch, sequential.
- Optional return-address stack (RAS) for call/return prediction.

Parameters:
- W, 32, PC width in bits
- INC, 4, sequential increment (bytes per instruction)
- RESET_VEC, 32'h0000_0000, PC value loaded on reset
- EXC_VEC, 32'h8000_0180, PC value loaded on exception
- RAS_DEPTH, 4, RAS entries (power of two, >=2); used only with PC_RAS_EN

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC (hazard stall)
- exc  in  1  redirect to EXC_VEC; overrides stall
- br_taken  in  1  conditional branch taken
- br_target  in  W  branch target
- jmp  in  1  unconditional jump
- jmp_target  in  W  jump target
- call  in  1  qualifies jmp as a call (push return address)
- ret  in  1  return
- ret_target  in  W  architectural return address (register value)
- pc_out  out  W  current PC (registered)
- pc_plus  out  W  pc_out + INC (combinational)
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_underflow  out  1  one-cycle pulse: ret accepted while RAS empty

Behaviour:
- Reset (async, any time, mid-stall included): pc_out=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_underflow=0. First fetch after release uses RESET_VEC.
- pc_out updates only on posedge clk. Redirect inputs sampled at edge N take effect at pc_out after edge N (1-cycle latency).
- pc_plus = pc_out + INC, modulo 2^W. 0xFFFFFFFC + 4 wraps to 0x0. All target arithmetic is truncated to W bits.
- Next-PC priority, highest first:
  - exc -> EXC_VEC
  - stall -> hold pc_out. The old behaviour of outputting pc-4 is not used.
  - ret -> return target
  - jmp -> jmp_target
  - br_taken -> br_target
  - otherwise -> pc_plus
- When stall=1 and exc=0, all other inputs are ignored: no RAS push or pop, no underflow pulse.
- exc never changes RAS contents. Pushes and pops are suppressed in an exc cycle.
- call is meaningful only with jmp=1 and ret=0. call without jmp is ignored.
- RAS (PC_RAS_EN):
  - Circular buffer with top pointer and saturating count 0..RAS_DEPTH.
  - Push (jmp&call, accepted): write pc_plus at top+1, top++, count=min(count+1,RAS_DEPTH). Push when full overwrites the oldest entry silently; ras_full stays 1.
  - Pop (ret, accepted, count>0): next PC = entry[top], top--, count--.
  - ret with count=0: next PC = ret_target, ras_underflow=1 for one cycle, count stays 0.
  - ret together with jmp&call: ret wins the redirect. entry[top] is replaced by pc_plus and count is unchanged (if empty: push only, target=ret_target, underflow pulses).
- ras_empty = (count==0) and ras_full = (count==RAS_DEPTH), both registered-state-derived.

Optional Feature:
- Macro PC_RAS_EN.
- Defined: RAS as described above; ret uses the stack top when non-empty.
- Undefined: no RAS storage. ret always redirects to ret_target. call is ignored. ras_empty=1, ras_full=0, ras_underflow=0 constantly.

Test Plan:
- Reset release, no redirects, 4 cycles -> pc_out 0x0, 0x4, 0x8, 0xC. Assert rst mid-run -> pc_out=0x0 immediately, without a clock edge.
- stall=1 for 3 cycles at pc 0x10 -> pc_out holds 0x10 (never 0xC). Release -> 0x14. Same cycle as stall: exc=1 -> next pc 0x80000180.
- br_taken=1, br_target=0x100, jmp=1, jmp_target=0x200 together -> 0x200. br alone -> 0x100. Load pc 0xFFFFFFFC, sequential -> 0x0.
- PC_RAS_EN: call at pc 0x40 (jmp_target 0x400) -> pc 0x400, ras_empty=0. ret with ret_target=0x999 -> pc 0x44 and ras_empty=1. Second ret -> pc 0x999, ras_underflow pulses 1 cycle.
- PC_RAS_EN, RAS_DEPTH=4: 5 calls from pcs 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_full=1. 4 rets -> 0x44, 0x34, 0x24, 0x14. 5th ret -> ret_target, underflow pulse.
- Macro undefined: call at 0x40 then ret with ret_target=0x80 -> pc 0x80, ras_empty stays 1, no underflow pulse.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-stage PC bus: redirect requests in, current PC and RAS status out.
// The fetch/control side is the master; pc_unit is the slave.
interface pc_unit_if #(
    parameter int W = 32
);
    logic         stall;
    logic         exc;
    logic         br_taken;
    logic [W-1:0] br_target;
    logic         jmp;
    logic [W-1:0] jmp_target;
    logic         call;
    logic         ret;
    logic [W-1:0] ret_target;
    logic [W-1:0] pc_out;
    logic [W-1:0] pc_plus;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_underflow;

    modport master (
        output stall, exc, br_taken, br_target, jmp, jmp_target,
               call, ret, ret_target,
        input  pc_out, pc_plus, ras_empty, ras_full, ras_underflow
    );

    modport slave (
        input  stall, exc, br_taken, br_target, jmp, jmp_target,
               call, ret, ret_target,
        output pc_out, pc_plus, ras_empty, ras_full, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit with prioritised next-PC selection.
// Define PC_RAS_EN to build the return-address stack for call/return prediction.
module pc_unit #(
    parameter int           W         = 32,
    parameter int           INC       = 4,
    parameter logic [W-1:0] RESET_VEC = W'(32'h0000_0000),
    parameter logic [W-1:0] EXC_VEC   = W'(32'h8000_0180),
    parameter int           RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    pc_unit_if.slave bus
);
    localparam logic [W-1:0] INC_W = W'(INC);

    logic [W-1:0] pc;
    logic [W-1:0] pc_plus;
    logic [W-1:0] pc_next;
    logic [W-1:0] ret_addr;
    logic         accept;

    assign pc_plus     = pc + INC_W;
    assign accept      = !bus.exc && !bus.stall;
    assign bus.pc_out  = pc;
    assign bus.pc_plus = pc_plus;

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [W-1:0]     ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic [CNT_W-1:0] count;
    logic             underflow_q;
    logic             ras_has;
    logic             do_ret;
    logic             do_call;

    assign top_inc = top + 1'b1;
    assign top_dec = top - 1'b1;
    assign ras_has = (count != '0);
    assign do_ret  = accept && bus.ret;
    assign do_call = accept && bus.jmp && bus.call;
    assign ret_addr = ras_has ? ras_mem[top] : bus.ret_target;

    assign bus.ras_empty     = !ras_has;
    assign bus.ras_full      = (count == FULL_CNT);
    assign bus.ras_underflow = underflow_q;

    // ret+call with a live top swaps the top entry in place; an empty
    // stack makes the same combination degrade to a plain push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top         <= '0;
            count       <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            underflow_q <= do_ret && !ras_has;
            if (do_ret && do_call && ras_has) begin
                ras_mem[top] <= pc_plus;
            end else if (do_call) begin
                ras_mem[top_inc] <= pc_plus;
                top              <= top_inc;
                if (count != FULL_CNT) begin
                    count <= count + 1'b1;
                end
            end else if (do_ret && ras_has) begin
                top   <= top_dec;
                count <= count - 1'b1;
            end
        end
    end
`else
    logic unused_call;

    assign unused_call       = &{1'b0, bus.call};
    assign ret_addr          = bus.ret_target;
    assign bus.ras_empty     = 1'b1;
    assign bus.ras_full      = 1'b0;
    assign bus.ras_underflow = 1'b0;
`endif

    // Exception beats stall; stall freezes the PC outright.
    always_comb begin
        pc_next = pc_plus;
        if (bus.exc) begin
            pc_next = EXC_VEC;
        end else if (bus.stall) begin
            pc_next = pc;
        end else if (bus.ret) begin
            pc_next = ret_addr;
        end else if (bus.jmp) begin
            pc_next = bus.jmp_target;
        end else if (bus.br_taken) begin
            pc_next = bus.br_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; RAS scenarios follow PC_RAS_EN.
module tb_pc_unit;
    logic clk;
    logic rst;
    int   check_count;
    int   pass_count;

    pc_unit_if #(.W(32)) bus ();

    pc_unit #(
        .W(32), .INC(4), .RESET_VEC(32'h0), .EXC_VEC(32'h8000_0180), .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of redirect inputs, clock once, settle past the edge.
    task automatic applyStimulus(input logic st, input logic ex,
                                 input logic br, input logic [31:0] brt,
                                 input logic jm, input logic [31:0] jt,
                                 input logic cl, input logic rt,
                                 input logic [31:0] rtt);
        bus.stall      = st;
        bus.exc        = ex;
        bus.br_taken   = br;
        bus.br_target  = brt;
        bus.jmp        = jm;
        bus.jmp_target = jt;
        bus.call       = cl;
        bus.ret        = rt;
        bus.ret_target = rtt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] t);
        applyStimulus(0, 0, 0, 32'h0, 1, t, 0, 0, 32'h0);
    endtask

    task automatic doCall(input logic [31:0] t);
        applyStimulus(0, 0, 0, 32'h0, 1, t, 1, 0, 32'h0);
    endtask

    task automatic doRet(input logic [31:0] rtt);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, rtt);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst = 1'b1;
        bus.stall = 0; bus.exc = 0; bus.br_taken = 0; bus.br_target = 0;
        bus.jmp = 0; bus.jmp_target = 0; bus.call = 0; bus.ret = 0; bus.ret_target = 0;
        #1;
        checkOutput("reset_pc", bus.pc_out, 32'h0);
        checkOutput("reset_empty", {31'b0, bus.ras_empty}, 32'h1);
        checkOutput("reset_full", {31'b0, bus.ras_full}, 32'h0);
        checkOutput("reset_uflow", {31'b0, bus.ras_underflow}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("seq_0", bus.pc_out, 32'h4);
        idle(); checkOutput("seq_1", bus.pc_out, 32'h8);
        idle(); checkOutput("seq_2", bus.pc_out, 32'hC);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", bus.pc_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) idle();
        checkOutput("pc_at_10", bus.pc_out, 32'h10);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 32'h300, 1, 32'h300, 0, 1, 32'h300);
            checkOutput("stall_hold", bus.pc_out, 32'h10);
        end
        idle(); checkOutput("stall_release", bus.pc_out, 32'h14);
        applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("exc_over_stall", bus.pc_out, 32'h8000_0180);
        applyStimulus(0, 0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0);
        checkOutput("jmp_over_br", bus.pc_out, 32'h200);
        applyStimulus(0, 0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("br_alone", bus.pc_out, 32'h100);
        jump(32'hFFFF_FFFC);
        checkOutput("pc_top", bus.pc_out, 32'hFFFF_FFFC);
        checkOutput("pc_plus_wrap", bus.pc_plus, 32'h0);
        idle(); checkOutput("seq_wrap", bus.pc_out, 32'h0);

`ifdef PC_RAS_EN
        jump(32'h40);
        doCall(32'h400);
        checkOutput("call_pc", bus.pc_out, 32'h400);
        checkOutput("call_nonempty", {31'b0, bus.ras_empty}, 32'h0);
        doRet(32'h999);
        checkOutput("ret_pred", bus.pc_out, 32'h44);
        checkOutput("ret_empty", {31'b0, bus.ras_empty}, 32'h1);
        checkOutput("ret_no_uflow", {31'b0, bus.ras_underflow}, 32'h0);
        doRet(32'h999);
        checkOutput("uflow_pc", bus.pc_out, 32'h999);
        checkOutput("uflow_pulse", {31'b0, bus.ras_underflow}, 32'h1);
        idle();
        checkOutput("uflow_clear", {31'b0, bus.ras_underflow}, 32'h0);

        jump(32'h0);
        doCall(32'h10); doCall(32'h20); doCall(32'h30); doCall(32'h40);
        checkOutput("full_at_4", {31'b0, bus.ras_full}, 32'h1);
        doCall(32'h50);
        checkOutput("full_after_wrap", {31'b0, bus.ras_full}, 32'h1);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
        checkOutput("exc_no_pop", {31'b0, bus.ras_full}, 32'h1);
        doRet(32'h777); checkOutput("ret_1", bus.pc_out, 32'h44);
        doRet(32'h777); checkOutput("ret_2", bus.pc_out, 32'h34);
        doRet(32'h777); checkOutput("ret_3", bus.pc_out, 32'h24);
        doRet(32'h777); checkOutput("ret_4", bus.pc_out, 32'h14);
        doRet(32'h777);
        checkOutput("ret_5_pc", bus.pc_out, 32'h777);
        checkOutput("ret_5_uflow", {31'b0, bus.ras_underflow}, 32'h1);

        doCall(32'h500);
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h600, 1, 1, 32'h111);
        checkOutput("swap_pc", bus.pc_out, 32'h77B);
        checkOutput("swap_nonempty", {31'b0, bus.ras_empty}, 32'h0);
        doRet(32'h111);
        checkOutput("swap_ret", bus.pc_out, 32'h504);
        checkOutput("swap_empty", {31'b0, bus.ras_empty}, 32'h1);
`else
        jump(32'h40);
        doCall(32'h400);
        checkOutput("nras_call_pc", bus.pc_out, 32'h400);
        checkOutput("nras_empty_1", {31'b0, bus.ras_empty}, 32'h1);
        doRet(32'h80);
        checkOutput("nras_ret_pc", bus.pc_out, 32'h80);
        checkOutput("nras_empty_2", {31'b0, bus.ras_empty}, 32'h1);
        checkOutput("nras_no_uflow", {31'b0, bus.ras_underflow}, 32'h0);
        checkOutput("nras_not_full", {31'b0, bus.ras_full}, 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
